// File: rtl/uart_rx.sv
// +----------------------------------------------------------------------------+
// | Module   : uart_rx                                                          |
// | Brief    : Oversampled UART receiver with framing-error and overrun flags.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    input  logic               i_rd,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_rx_valid,
    output logic               o_frame_err,
    output logic               o_overrun
);

    localparam int TW = (NB_STOP > 1) ? $clog2(NB_STOP) : 1;
    localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TW-1:0] c_TICK_MID  = TW'(NB_STOP / 2 - 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(NB_STOP - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        RECEIVE   = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [TW-1:0]        r_tick_cnt;
    logic [TW-1:0]        w_tick_cnt_n;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_bit_cnt_n;
    logic [NB_DATA-1:0]   r_shreg;
    logic [NB_DATA-1:0]   w_shreg_n;
    logic [NB_DATA-1:0]   r_data;
    logic                 r_rxdone;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_done;
    logic                 w_ferr;

    always_comb begin
        w_state_n    = r_state;
        w_tick_cnt_n = r_tick_cnt;
        w_bit_cnt_n  = r_bit_cnt;
        w_shreg_n    = r_shreg;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_n    = START;
                    w_tick_cnt_n = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (!r_rx_s) begin
                            w_state_n    = RECEIVE;
                            w_tick_cnt_n = '0;
                            w_bit_cnt_n  = '0;
                        end else begin
                            w_state_n = IDLE;
                        end
                    end else begin
                        w_tick_cnt_n = r_tick_cnt + 1'b1;
                    end
                end
            end
            RECEIVE: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_shreg_n    = {r_rx_s, r_shreg[NB_DATA-1:1]};
                        w_tick_cnt_n = '0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_n = STOP;
                        end else begin
                            w_bit_cnt_n = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_n = r_tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_cnt_n = '0;
                        if (r_rx_s) begin
                            w_done    = 1'b1;
                            w_state_n = IDLE;
                        end else begin
                            w_ferr    = 1'b1;
                            w_state_n = WAIT_IDLE;
                        end
                    end else begin
                        w_tick_cnt_n = r_tick_cnt + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold here through a break so it reports only one framing error.
                if (r_rx_s) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_rxdone    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_rx_meta   <= i_rx;
            r_rx_s      <= r_rx_meta;
            r_tick_cnt  <= w_tick_cnt_n;
            r_bit_cnt   <= w_bit_cnt_n;
            r_shreg     <= w_shreg_n;
            r_rxdone    <= w_done;
            r_frame_err <= w_ferr;
            // A completing byte takes priority over a simultaneous read.
            if (w_done) begin
                r_data     <= r_shreg;
                r_rx_valid <= 1'b1;
                r_overrun  <= i_rd ? 1'b0 : (r_overrun | r_rx_valid);
            end else if (i_rd) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_rxdone    = r_rxdone;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                       |
// | Brief    : Directed self-checking bench for uart_rx (16x oversampling).     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

    localparam int c_BIT_CLKS = 64;

    logic       clk;
    logic       i_rst;
    logic       i_tick;
    logic       i_rx;
    logic       i_rd;
    logic [7:0] o_data;
    logic       o_rxdone;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_overrun;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int done0;
    int ferr0;
    bit seen;

    uart_rx #(.NB_DATA(8), .NB_STOP(16)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .i_rd       (i_rd),
        .o_data     (o_data),
        .o_rxdone   (o_rxdone),
        .o_rx_valid (o_rx_valid),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        i_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            i_tick = 1'b1;
            @(negedge clk);
            i_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (o_rxdone)                done_cnt = done_cnt + 1;
        if (o_frame_err)             ferr_cnt = ferr_cnt + 1;
        if (o_rxdone && o_frame_err) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold_line(input logic v, input int clks);
        i_rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b);
        hold_line(1'b0, c_BIT_CLKS);
        for (int k = 0; k < 8; k++) hold_line(b[k], c_BIT_CLKS);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b);
        hold_line(1'b1, c_BIT_CLKS);
    endtask

    task automatic rd_pulse();
        @(negedge clk);
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        i_rst = 1'b1;
        i_rx  = 1'b1;
        i_rd  = 1'b0;
        repeat (4) @(negedge clk);
        i_rst = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_data",    32'(o_data), 32'h00);
        chk("rst_valid",   32'(o_rx_valid), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        chk("rst_rxdone",  32'(o_rxdone), 32'd0);
        chk("rst_ferr",    32'(o_frame_err), 32'd0);

        // Plain frame
        send_byte(8'hA5);
        chk("a5_data",  32'(o_data), 32'hA5);
        chk("a5_done",  32'(done_cnt), 32'd1);
        chk("a5_valid", 32'(o_rx_valid), 32'd1);
        chk("a5_ferr",  32'(ferr_cnt), 32'd0);

        // False start: 4 ticks low
        rd_pulse();
        done0 = done_cnt;
        ferr0 = ferr_cnt;
        hold_line(1'b0, 16);
        hold_line(1'b1, 2 * c_BIT_CLKS);
        chk("glitch_done",  32'(done_cnt - done0), 32'd0);
        chk("glitch_ferr",  32'(ferr_cnt - ferr0), 32'd0);
        chk("glitch_valid", 32'(o_rx_valid), 32'd0);

        // Framing error followed by a break, then recovery
        done0 = done_cnt;
        ferr0 = ferr_cnt;
        send_bits(8'h3C);
        hold_line(1'b0, 4 * c_BIT_CLKS);
        hold_line(1'b1, c_BIT_CLKS);
        chk("ferr_count", 32'(ferr_cnt - ferr0), 32'd1);
        chk("ferr_done",  32'(done_cnt - done0), 32'd0);
        chk("ferr_data",  32'(o_data), 32'hA5);
        chk("ferr_valid", 32'(o_rx_valid), 32'd0);
        send_byte(8'h55);
        chk("rec_data",  32'(o_data), 32'h55);
        chk("rec_valid", 32'(o_rx_valid), 32'd1);
        chk("rec_done",  32'(done_cnt - done0), 32'd1);

        // Overrun with back-to-back frames
        rd_pulse();
        chk("pre_ovr_valid", 32'(o_rx_valid), 32'd0);
        send_byte(8'h11);
        chk("ovr_first_ovr", 32'(o_overrun), 32'd0);
        send_byte(8'h22);
        chk("ovr_data",    32'(o_data), 32'h22);
        chk("ovr_overrun", 32'(o_overrun), 32'd1);
        chk("ovr_valid",   32'(o_rx_valid), 32'd1);
        rd_pulse();
        chk("rd_valid",   32'(o_rx_valid), 32'd0);
        chk("rd_overrun", 32'(o_overrun), 32'd0);

        // Reset during data bit 3 of 0xF0
        done0 = done_cnt;
        ferr0 = ferr_cnt;
        hold_line(1'b0, c_BIT_CLKS);
        for (int k = 0; k < 3; k++) hold_line(1'b0, c_BIT_CLKS);
        hold_line(1'b0, c_BIT_CLKS / 2);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        hold_line(1'b1, 2 * c_BIT_CLKS);
        chk("abort_data", 32'(o_data), 32'h00);
        chk("abort_done", 32'(done_cnt - done0), 32'd0);
        chk("abort_ferr", 32'(ferr_cnt - ferr0), 32'd0);
        send_byte(8'h0F);
        chk("post_rst_data", 32'(o_data), 32'h0F);
        chk("post_rst_done", 32'(done_cnt - done0), 32'd1);

        // Read coinciding with completion: the byte wins
        send_bits(8'h7E);
        i_rx = 1'b1;
        i_rd = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 2 * c_BIT_CLKS && !seen; n++) begin
            @(negedge clk);
            if (o_rxdone) seen = 1'b1;
        end
        i_rd = 1'b0;
        chk("coinc_seen", 32'(seen), 32'd1);
        hold_line(1'b1, c_BIT_CLKS);
        chk("coinc_data",    32'(o_data), 32'h7E);
        chk("coinc_valid",   32'(o_rx_valid), 32'd1);
        chk("coinc_overrun", 32'(o_overrun), 32'd0);
        chk("never_both",    32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
